// File: rtl/reg_context_engine_if.sv
// Bus bundle for reg_context_engine: control, register-file port and memory port.
// Optional CTX_ABORT_EN adds the abort/aborted pair.
interface reg_context_engine_if #(
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    // Memory handshake: mem_req holds, with mem_addr/mem_we/mem_wdata stable, until
    // mem_ack is sampled high; the transfer completes on the edge where both are high.
    logic                  start;
    logic                  dir;
    logic [REG_COUNT-1:0]  mask;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [2:0]            reg_num;
    logic                  reg_cs_out;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  reg_cs_in;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;
    logic [2:0]            state_dbg;
`ifdef CTX_ABORT_EN
    logic                  abort;
    logic                  aborted;
`endif

    modport master (
        input  start, dir, mask, base_addr, reg_rdata, mem_rdata, mem_ack,
        output busy, done, end_addr, reg_num, reg_cs_out, reg_cs_in, reg_wdata,
               mem_req, mem_we, mem_addr, mem_wdata, state_dbg
`ifdef CTX_ABORT_EN
        , input abort, output aborted
`endif
    );

    modport slave (
        output start, dir, mask, base_addr, reg_rdata, mem_rdata, mem_ack,
        input  busy, done, end_addr, reg_num, reg_cs_out, reg_cs_in, reg_wdata,
               mem_req, mem_we, mem_addr, mem_wdata, state_dbg
`ifdef CTX_ABORT_EN
        , output abort, input aborted
`endif
    );
endinterface

// File: rtl/reg_context_engine.sv
// Register-file <-> memory context save/restore sequencer.
// Optional feature macro: CTX_ABORT_EN (abort input, aborted output).
module reg_context_engine #(
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    reg_context_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, SCAN, READ, MEM, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  dir_q;
    logic [REG_COUNT-1:0]  pending_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] end_addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            idx_q;
    logic [2:0]            low_idx;
    logic                  found;
    logic                  stop_scan;

    // Lowest set pending bit wins: scan downwards so the last hit is the lowest.
    always_comb begin
        found   = 1'b0;
        low_idx = 3'd0;
        for (int i = REG_COUNT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                found   = 1'b1;
                low_idx = 3'(i);
            end
        end
    end

`ifdef CTX_ABORT_EN
    logic abort_q;
    assign stop_scan = abort_q;

    // Sticky until DONE hands back to IDLE; the in-flight transfer still finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 abort_q <= 1'b0;
        else if (state_q == DONE)                abort_q <= 1'b0;
        else if (state_q != IDLE && bus.abort)   abort_q <= 1'b1;
    end

    assign bus.aborted = (state_q == DONE) && abort_q;
`else
    assign stop_scan = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN: begin
                if (!found || stop_scan) state_d = DONE;
                else if (dir_q)          state_d = MEM;
                else                     state_d = READ;
            end
            READ:    state_d = MEM;
            MEM:     if (bus.mem_ack) state_d = dir_q ? WRITE : SCAN;
            WRITE:   state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            pending_q  <= '0;
            addr_q     <= '0;
            end_addr_q <= '0;
            data_q     <= '0;
            idx_q      <= 3'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dir_q     <= bus.dir;
                        pending_q <= bus.mask;
                        addr_q    <= bus.base_addr;
                    end
                end
                SCAN: begin
                    idx_q <= low_idx;
                    if (state_d == DONE) end_addr_q <= addr_q;
                end
                READ:    data_q <= bus.reg_rdata;
                MEM: begin
                    if (bus.mem_ack) begin
                        pending_q[idx_q] <= 1'b0;
                        addr_q           <= addr_q + ADDR_WIDTH'(1);
                        if (dir_q) data_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from the state register alone, so reset clears them at once.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
        bus.end_addr   = end_addr_q;
        bus.reg_num    = (state_q == READ || state_q == WRITE) ? idx_q : 3'd0;
        bus.reg_cs_out = (state_q == READ);
        bus.reg_cs_in  = (state_q == WRITE);
        bus.reg_wdata  = (state_q == WRITE) ? data_q : '0;
        bus.mem_req    = (state_q == MEM);
        bus.mem_we     = (state_q == MEM) && !dir_q;
        bus.mem_addr   = (state_q == MEM) ? addr_q : '0;
        bus.mem_wdata  = (state_q == MEM && !dir_q) ? data_q : '0;
        bus.state_dbg  = state_q;
    end
endmodule

// File: tb/tb_reg_context_engine.sv
// Directed bench for reg_context_engine: register-file and memory models, write log,
// cycle-accurate done timing, reset abort, and the optional abort feature.
module tb_reg_context_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_context_engine_if #(.REG_COUNT(8), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  reg_context_engine #(.REG_COUNT(8), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Register file model.
  logic [7:0] regs [0:7] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
  assign bus.reg_rdata = regs[bus.reg_num];
  always @(posedge clk) if (bus.reg_cs_in) regs[bus.reg_num] <= bus.reg_wdata;

  // Memory model: fixed read image, configurable ack latency.
  int ack_delay = 0;
  int wait_cnt = 0;
  assign bus.mem_ack = bus.mem_req && (wait_cnt == ack_delay);
  assign bus.mem_rdata = (bus.mem_addr == 16'h2000) ? 8'h11 :
                         (bus.mem_addr == 16'h2001) ? 8'h77 : 8'h00;
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Monitor: write log, stability during waits, exclusivity, pulse counters.
  logic [23:0] wr_log[$];
  int cs_in_cnt = 0, req_cnt = 0, stab_err = 0, excl_err = 0;
  logic prev_wait = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0] p_wdata = '0;
  logic p_we = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack && bus.mem_we) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.reg_cs_in) cs_in_cnt <= cs_in_cnt + 1;
    if (bus.mem_req) req_cnt <= req_cnt + 1;
    if ((32'(bus.reg_cs_out) + 32'(bus.reg_cs_in) + 32'(bus.mem_req)) > 1) excl_err <= excl_err + 1;
    if (!rst && prev_wait && (bus.mem_req !== 1'b1 || bus.mem_addr !== p_addr ||
        bus.mem_wdata !== p_wdata || bus.mem_we !== p_we))
      stab_err <= stab_err + 1;
    prev_wait <= !rst && bus.mem_req && !bus.mem_ack;
    p_addr <= bus.mem_addr;
    p_wdata <= bus.mem_wdata;
    p_we <= bus.mem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  int log0, cs0, req0, stab0;
  logic last_aborted;

  // Starts one operation and returns the cycle of the done pulse (-1 on timeout).
  task automatic run_op(input logic d, input logic [7:0] m, input logic [15:0] b,
                        input int dly, input int ab_cyc,
                        output int dc, output logic [15:0] ea);
    log0 = wr_log.size();
    cs0 = cs_in_cnt;
    req0 = req_cnt;
    stab0 = stab_err;
    ack_delay = dly;
    last_aborted = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = d; bus.mask = m; bus.base_addr = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dir = ~d; bus.mask = 8'hFF; bus.base_addr = 16'hDEAD;
    dc = -1;
    ea = '0;
    for (int c = 1; c < 200; c++) begin
`ifdef CTX_ABORT_EN
      bus.abort = (c == ab_cyc);
`endif
      @(negedge clk);
      if (bus.done) begin
        dc = c;
        ea = bus.end_addr;
`ifdef CTX_ABORT_EN
        last_aborted = bus.aborted;
`endif
        break;
      end
      @(posedge clk); #1;
    end
`ifdef CTX_ABORT_EN
    bus.abort = 1'b0;
`endif
    if (ab_cyc < 0) $display("[TB] unused abort cycle %0d", ab_cyc);
  endtask

  int dc;
  logic [15:0] ea;

  initial begin
    bus.start = 1'b0; bus.dir = 1'b0; bus.mask = '0; bus.base_addr = '0;
`ifdef CTX_ABORT_EN
    bus.abort = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_outs", {bus.done, bus.mem_req, bus.mem_we, bus.reg_cs_out, bus.reg_cs_in}, 0);
    check("rst_buses", {bus.mem_addr, bus.mem_wdata, bus.reg_wdata}, 0);
    check("rst_misc", {bus.end_addr, 5'b0, bus.reg_num, bus.state_dbg}, 0);
    rst = 1'b0;

    // Save r0, r2 to 0x0100.
    run_op(1'b0, 8'h05, 16'h0100, 0, 0, dc, ea);
    check("t1_done_cyc", dc, 8);
    check("t1_end_addr", ea, 16'h0102);
    check("t1_nwrites", wr_log.size() - log0, 2);
    check("t1_w0", wr_log[log0], 24'h0100A1);
    check("t1_w1", wr_log[log0 + 1], 24'h0101C3);
    @(negedge clk);
    check("t1_idle_after", {bus.busy, bus.done}, 0);

    // Restore r0, r7 from 0x2000.
    run_op(1'b1, 8'h81, 16'h2000, 0, 0, dc, ea);
    check("t2_done_cyc", dc, 8);
    check("t2_end_addr", ea, 16'h2002);
    check("t2_r0", regs[0], 8'h11);
    check("t2_r7", regs[7], 8'h77);
    check("t2_r1_kept", regs[1], 8'hB2);
    check("t2_r6_kept", regs[6], 8'h07);
    check("t2_cs_in_pulses", cs_in_cnt - cs0, 2);
    check("t2_no_writes", wr_log.size() - log0, 0);

    // Save r1, r3 with three wait cycles per request.
    run_op(1'b0, 8'h0A, 16'h0300, 3, 0, dc, ea);
    check("t3_done_cyc", dc, 14);
    check("t3_end_addr", ea, 16'h0302);
    check("t3_stable", stab_err - stab0, 0);
    check("t3_w0", wr_log[log0], 24'h0300B2);
    check("t3_w1", wr_log[log0 + 1], 24'h0301D4);

    // Empty mask.
    run_op(1'b0, 8'h00, 16'h1234, 0, 0, dc, ea);
    check("t4_done_cyc", dc, 2);
    check("t4_end_addr", ea, 16'h1234);
    check("t4_no_req", req_cnt - req0, 0);

    // Address wrap.
    run_op(1'b0, 8'h03, 16'hFFFF, 0, 0, dc, ea);
    check("t5_done_cyc", dc, 8);
    check("t5_end_addr", ea, 16'h0001);
    check("t5_w0", wr_log[log0], 24'hFFFF11);
    check("t5_w1", wr_log[log0 + 1], 24'h0000B2);

    // Reset during a restore's memory wait.
    ack_delay = 20;
    @(negedge clk);
    bus.start = 1'b1; bus.dir = 1'b1; bus.mask = 8'h01; bus.base_addr = 16'h4000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_in_wait", {bus.mem_req, bus.mem_addr}, {1'b1, 16'h4000});
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.reg_cs_out, bus.reg_cs_in}, 0);
    check("t6_rst_bus", {bus.mem_addr, bus.mem_wdata, bus.reg_wdata}, 0);
    check("t6_r0_kept", regs[0], 8'h11);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 8'h10, 16'h5000, 0, 0, dc, ea);
    check("t6_after_done_cyc", dc, 5);
    check("t6_after_end_addr", ea, 16'h5001);
    check("t6_after_w0", wr_log[log0], 24'h5000E5);

`ifdef CTX_ABORT_EN
    // Abort during the first of four transfers.
    run_op(1'b0, 8'h0F, 16'h6000, 2, 2, dc, ea);
    check("t7_done_cyc", dc, 7);
    check("t7_aborted", 32'(last_aborted), 1);
    check("t7_end_addr", ea, 16'h6001);
    check("t7_nwrites", wr_log.size() - log0, 1);
    check("t7_w0", wr_log[log0], 24'h600011);
`endif

    check("exclusive_enables", excl_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
